wide_write_sequencer: RTL
=========================

WIDE_WRITE_SEQUENCER -- requirements
Module: wide_write_sequencer

Interface
REQ-001 SHALL have parameter: AW, 6, word address width; byte address width is AW+2.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  word write request valid.
REQ-005 SHALL have port: in_ready  output  1  sequencer can accept a word this cycle.
REQ-006 SHALL have port: in_we  input  4  byte-lane enables, bit n = byte lane n.
REQ-007 SHALL have port: in_wa  input  AW  word address.
REQ-008 SHALL have port: in_wd  input  32  word data, lane n = bits [8n+7:8n].
REQ-009 SHALL have port: mem_ready  input  1  memory byte port grants a write this cycle.
REQ-010 SHALL have port: mem_we  output  1  byte write strobe.
REQ-011 SHALL have port: mem_addr  output  AW+2  byte address {word address, lane}.
REQ-012 SHALL have port: mem_wd  output  8  byte write data.
REQ-013 SHALL have port: mem_wwe  output  1  wide (full-word) write strobe.
REQ-014 SHALL have port: mem_wwd  output  32  wide write data.
REQ-015 SHALL have port: done  output  1  one-cycle pulse when a word's last write completes.
REQ-016 SHALL have port: busy  output  1  high while a word is held.

Function
REQ-017 SHALL implement states IDLE and WRITE; in_ready = (IDLE) or (WRITE, last pending lane, mem_ready).
REQ-018 SHALL, on in_valid & in_ready, latch in_wa, in_wd, in_we into word/data/pending registers.
REQ-019 SHALL accept a word with in_we==0 without issuing any write, pulse done next cycle, stay in IDLE.
REQ-020 SHALL, in WRITE, drive mem_we=1, mem_addr={word,lane}, mem_wd=byte of the lowest-numbered pending lane, combinationally.
REQ-021 SHALL hold mem_addr/mem_wd stable and keep the lane pending while mem_ready=0.
REQ-022 SHALL clear the issued lane on mem_we & mem_ready; lanes issued strictly ascending, disabled lanes skipped with no idle cycle.
REQ-023 SHALL, when the last pending lane is granted, pulse done next cycle and go to IDLE, or stay in WRITE with the new word if one is accepted the same cycle.
REQ-024 SHALL give minimum throughput of k granted cycles per word with k enabled lanes, zero bubble back-to-back.
REQ-025 SHALL drive busy=1 exactly when in WRITE; mem_we=0 and mem_wwe=0 in IDLE.

Reset
REQ-026 SHALL, on rst high, immediately enter IDLE, clear pending lanes, drive mem_we=0, mem_wwe=0, done=0, busy=0, in_ready=0 while rst high.
REQ-027 SHALL discard any partially issued word on reset mid-operation; no further lanes of it issued.
REQ-028 SHALL clear word/data registers to 0 on reset; in_ready=1 first cycle after release.

Configuration
REQ-029 SHALL, with WIDE_WRITE_SEQUENCER_COALESCE_EN defined, issue a word with all four lanes enabled as one mem_wwe cycle (mem_wwd=data, mem_addr={word,2'b00}, mem_we=0), completing on mem_ready.
REQ-030 SHALL, without WIDE_WRITE_SEQUENCER_COALESCE_EN, tie mem_wwe=0, mem_wwd=0 and issue all words as byte writes.

Verification
REQ-031 SHALL cover: we=4'b1111, wa=6'h05, wd=32'hDDCCBBAA, mem_ready=1, macro off -> byte writes 0x14=AA,0x15=BB,0x16=CC,0x17=DD on 4 consecutive cycles, done 1 cycle later.
REQ-032 SHALL cover: we=4'b1010, wa=6'h3F, wd=32'h44332211 -> writes 0xFD=22, 0xFF=44 in 2 consecutive cycles, lanes 0/2 never strobed.
REQ-033 SHALL cover: mem_ready held 0 for 3 cycles during lane 1 of we=4'b0011 -> mem_addr/mem_wd unchanged for 3 cycles, in_ready=0, lane 1 written once.
REQ-034 SHALL cover: two back-to-back words we=4'b0001 then 4'b1000 -> writes on consecutive cycles, no bubble, two done pulses.
REQ-035 SHALL cover: rst asserted after lane 0 of we=4'b1111 -> mem_we=0 same cycle, remaining lanes never written, busy=0.
REQ-036 SHALL cover: macro on, we=4'b1111, wa=6'h01, wd=32'h12345678 -> one cycle mem_wwe=1, mem_addr=0x04, mem_wwd=32'h12345678, mem_we=0.

Source files
------------

// File: rtl/wide_write_sequencer.sv
// wide_write_sequencer
// Breaks a 32-bit word write with byte-lane enables into byte writes on an
// 8-bit memory port. Lanes go out in ascending order, and disabled lanes are
// skipped. A new word can be accepted in the same cycle that the last lane of
// the current word is granted, so back-to-back words run with no bubble.
//
// Optional feature: define WIDE_WRITE_SEQUENCER_COALESCE_EN to issue a
// full-word write (all four lanes enabled) as a single mem_wwe cycle.
// The default build, with the macro undefined, issues byte writes only.
module wide_write_sequencer #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_we,
  input  logic [AW-1:0] in_wa,
  input  logic [31:0]   in_wd,
  input  logic          mem_ready,
  output logic          mem_we,
  output logic [AW+1:0] mem_addr,
  output logic [7:0]    mem_wd,
  output logic          mem_wwe,
  output logic [31:0]   mem_wwd,
  output logic          done,
  output logic          busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [AW-1:0] word_r;
  logic [31:0]   data_r;
  logic [3:0]    pend_r;
  logic          done_r;

  logic [1:0]    lane_s;
  logic [3:0]    low_s;
  logic          wide_s;
  logic          last_s;
  logic          grant_s;
  logic          accept_s;

  // Index of the lowest set bit of a lane mask (0 when the mask is empty).
  function automatic logic [1:0] low_lane(input logic [3:0] m);
    logic [1:0] l;
    l = 2'd0;
    if (m[0]) begin
      l = 2'd0;
    end else if (m[1]) begin
      l = 2'd1;
    end else if (m[2]) begin
      l = 2'd2;
    end else if (m[3]) begin
      l = 2'd3;
    end else begin
      l = 2'd0;
    end
    return l;
  endfunction

  // Byte n of a 32-bit word.
  function automatic logic [7:0] lane_byte(input logic [31:0] d, input logic [1:0] l);
    logic [7:0] b;
    b = 8'h00;
    case (l)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      2'd3:    b = d[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

`ifdef WIDE_WRITE_SEQUENCER_COALESCE_EN
  // A word whose four lanes are all still pending goes out as one wide write.
  assign wide_s = (pend_r == 4'b1111);
`else
  assign wide_s = 1'b0;
`endif

  // Current lane selection, last-lane detection and handshake terms.
  always_comb begin
    lane_s   = low_lane(pend_r);
    low_s    = 4'b0001 << lane_s;
    last_s   = wide_s || ((pend_r & ~low_s) == 4'b0000);
    grant_s  = (state_r == WRITE) && mem_ready;
    in_ready = !rst && ((state_r == IDLE) ||
                        ((state_r == WRITE) && last_s && mem_ready));
    accept_s = in_valid && in_ready;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && (in_we != 4'b0000)) begin
          state_s = WRITE;
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: begin
        if (grant_s && last_s) begin
          // Chain straight into the next word when one is taken this cycle.
          if (accept_s && (in_we != 4'b0000)) begin
            state_s = WRITE;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = WRITE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Word, data and pending-lane registers, and the completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_r <= '0;
      data_r <= 32'h0000_0000;
      pend_r <= 4'b0000;
      done_r <= 1'b0;
    end else begin
      done_r <= (grant_s && last_s) || (accept_s && (in_we == 4'b0000));
      if (accept_s) begin
        word_r <= in_wa;
        data_r <= in_wd;
        pend_r <= in_we;
      end else if (grant_s) begin
        pend_r <= wide_s ? 4'b0000 : (pend_r & ~low_s);
      end
    end
  end

  // Memory port and status outputs.
  always_comb begin
    busy     = (state_r == WRITE);
    done     = done_r;
    mem_we   = (state_r == WRITE) && !wide_s;
    mem_addr = {word_r, lane_s};
    mem_wd   = lane_byte(data_r, lane_s);
`ifdef WIDE_WRITE_SEQUENCER_COALESCE_EN
    mem_wwe  = (state_r == WRITE) && wide_s;
    mem_wwd  = data_r;
`else
    mem_wwe  = 1'b0;
    mem_wwd  = 32'h0000_0000;
`endif
  end

endmodule
